clk_meter: RTL and testbench

- Measures an incoming slow clock (clk_mon) in units of clk_in cycles.
- Reports its period and high time, and flags loss of clock.
- Receiving-end counterpart to the team's divided-clock generator: it checks generated clocks (e.g. the 25 MHz pixel clock) and monitors external clocks.
- Output is a per-period measurement with a one-cycle valid strobe.

---
 rtl/clk_meter_pkg.sv | 21 ++
 rtl/clk_meter_sync_edge.sv | 33 +++
 rtl/clk_meter.sv | 139 +++++++++++++
 tb/tb_clk_meter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/clk_meter_pkg.sv
// Shared definitions for the clock meter: FSM state encoding and the
// default counter width / loss-of-clock timeout.
package clk_meter_pkg;

    // Measurement FSM states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SYNC    = 2'd1,
        ST_MEASURE = 2'd2
    } meter_state_t;

    // Default counter width and timeout (timeout must fit in the counter).
    localparam int DEF_CNT_W          = 12;
    localparam int DEF_TIMEOUT_CYCLES = 4095;

    // Largest value representable in a counter of the given width.
    function automatic longint max_count(input int width);
        return (longint'(1) << width) - 1;
    endfunction

endpackage

// File: rtl/clk_meter_sync_edge.sv
// Two-flop synchroniser for an asynchronous input plus a delay flop
// providing a single-cycle rising-edge pulse. Reusable for any slow
// asynchronous level (monitored clocks, ADC strobes, buttons).
module sync_edge (
    input  logic clk_in,
    input  logic reset,
    input  logic async_i,
    output logic lvl_o,
    output logic rise_o
);

    logic meta_q;
    logic lvl_q;
    logic lvl_dly_q;

    // Synchronise the asynchronous input and keep one cycle of history.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            meta_q    <= 1'b0;
            lvl_q     <= 1'b0;
            lvl_dly_q <= 1'b0;
        end else begin
            meta_q    <= async_i;
            lvl_q     <= meta_q;
            lvl_dly_q <= lvl_q;
        end
    end

    assign lvl_o  = lvl_q;
    // Rising edge of the synchronised level, valid for exactly one cycle.
    assign rise_o = lvl_q & ~lvl_dly_q;

endmodule

// File: rtl/clk_meter.sv
// Clock meter: measures the period and high time of a slow monitored
// clock in clk_in cycles, emits a one-cycle valid strobe per period and
// raises a sticky loss-of-clock flag when no rising edge arrives within
// the timeout window.
module clk_meter
    import clk_meter_pkg::*;
#(
    parameter int CNT_W          = DEF_CNT_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             clk_mon,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             lost
);

    // The timeout has to be reachable by the counter without wrapping.
    generate
        if (TIMEOUT_CYCLES < 1 || longint'(TIMEOUT_CYCLES) > max_count(CNT_W)) begin : g_bad_timeout
            $error("clk_meter: TIMEOUT_CYCLES must be in 1 .. 2**CNT_W-1");
        end
    endgenerate

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic mon_lvl;
    logic mon_rise;

    sync_edge u_sync_edge (
        .clk_in  (clk_in),
        .reset   (reset),
        .async_i (clk_mon),
        .lvl_o   (mon_lvl),
        .rise_o  (mon_rise)
    );

    meter_state_t     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] hcnt_q;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] high_time_q;
    logic             valid_q;
    logic             lost_q;

    logic [CNT_W-1:0] cnt_inc_d;
    logic [CNT_W-1:0] hcnt_inc_d;
    logic [CNT_W-1:0] period_meas_d;
    logic             timeout_d;

    // Counter arithmetic shared by the SYNC and MEASURE states.
    always_comb begin
        cnt_inc_d     = cnt_q + 1'b1;
        hcnt_inc_d    = hcnt_q + CNT_W'(mon_lvl);
        // cnt counts cycles since the previous rise minus one, so the
        // period including the rise cycle itself is cnt+1.
        period_meas_d = cnt_q + 1'b1;
        // A rise on the last allowed cycle takes priority over timeout.
        timeout_d     = !mon_rise && (cnt_q == TIMEOUT_LAST);
    end

    // Measurement FSM with registered outputs.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            hcnt_q      <= '0;
            period_q    <= '0;
            high_time_q <= '0;
            valid_q     <= 1'b0;
            lost_q      <= 1'b0;
        end else if (!enable) begin
            // Disabling abandons any partial measurement; results and
            // the loss flag are kept for the consumer.
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hcnt_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cnt_q   <= '0;
                    hcnt_q  <= '0;
                    state_q <= ST_SYNC;
                end

                // Wait for the first edge; the partial period is thrown away.
                ST_SYNC: begin
                    if (mon_rise) begin
                        cnt_q   <= '0;
                        hcnt_q  <= CNT_W'(1);
                        state_q <= ST_MEASURE;
                    end else if (timeout_d) begin
                        lost_q <= 1'b1;
                        cnt_q  <= '0;
                    end else begin
                        cnt_q <= cnt_inc_d;
                    end
                end

                ST_MEASURE: begin
                    if (mon_rise) begin
                        period_q    <= period_meas_d;
                        high_time_q <= hcnt_q;
                        valid_q     <= 1'b1;
                        lost_q      <= 1'b0;
                        cnt_q       <= '0;
                        // The rise cycle itself is a sampled-high cycle.
                        hcnt_q      <= CNT_W'(1);
                    end else if (timeout_d) begin
                        lost_q  <= 1'b1;
                        cnt_q   <= '0;
                        hcnt_q  <= '0;
                        state_q <= ST_SYNC;
                    end else begin
                        cnt_q  <= cnt_inc_d;
                        hcnt_q <= hcnt_inc_d;
                    end
                end

                default: begin
                    cnt_q   <= '0;
                    hcnt_q  <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign period    = period_q;
    assign high_time = high_time_q;
    assign valid     = valid_q;
    assign lost      = lost_q;

endmodule

// File: tb/tb_clk_meter.sv
// Testbench for clk_meter: directed and randomised clk_mon waveforms,
// an event-level reference model compared every cycle, and a few
// hand-computed expectations.
module tb_clk_meter;

    localparam int CNT_W = 12;
    localparam int TO    = 4095;

    logic             clk_in = 1'b0;
    logic             reset;
    logic             enable;
    logic             clk_mon;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             valid;
    logic             lost;

    int checks = 0;
    int errors = 0;

    clk_meter #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(TO)) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .enable    (enable),
        .clk_mon   (clk_mon),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .lost      (lost)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Works on edge indices: n is the current clk_in edge, anchor is the
    // edge at which timing restarted. A period is the distance between
    // two rise edges; the high time is the number of high synchronised
    // samples recorded since the anchor.
    int  n, anchor, mode;            // mode: 0 off, 1 waiting for edge, 2 measuring
    bit  smp1, smp2, lvl_prev;       // clk_mon as seen 1 and 2 edges late
    int  hist[$];
    int  exp_period, exp_high, exp_valid, exp_lost;
    int  valid_seen;

    always @(posedge clk_in or posedge reset) begin
        bit lv;
        bit rs;
        int s;
        if (reset) begin
            n = 0; anchor = 0; mode = 0;
            smp1 = 0; smp2 = 0; lvl_prev = 0;
            hist.delete();
            exp_period = 0; exp_high = 0; exp_valid = 0; exp_lost = 0;
        end else begin
            lv = smp2;
            rs = lv & ~lvl_prev;
            exp_valid = 0;
            if (!enable) begin
                mode = 0;
            end else if (mode == 0) begin
                mode = 1; anchor = n; hist.delete();
            end else if (rs) begin
                if (mode == 2) begin
                    s = 0;
                    foreach (hist[i]) s += hist[i];
                    exp_period = n - anchor;
                    exp_high   = s;
                    exp_valid  = 1;
                    exp_lost   = 0;
                end
                mode = 2; anchor = n; hist.delete();
            end else if (n - anchor == TO) begin
                exp_lost = 1; mode = 1; anchor = n; hist.delete();
            end
            if (mode != 0) hist.push_back(int'(lv));
            lvl_prev = smp2;
            smp2 = smp1;
            smp1 = clk_mon;
            n++;
        end
    end

    // Per-cycle comparison, sampled after the outputs settle.
    always @(posedge clk_in) begin
        #1;
        if (!reset) begin
            chk("period",    int'(period),    exp_period);
            chk("high_time", int'(high_time), exp_high);
            chk("valid",     int'(valid),     exp_valid);
            chk("lost",      int'(lost),      exp_lost);
            if (valid) valid_seen++;
        end
    end

    // ---------------- stimulus ----------------
    // Drive one clk_mon period: h cycles high then l cycles low.
    task automatic mon(input int h, input int l);
        clk_mon = 1'b1;
        repeat (h) @(negedge clk_in);
        clk_mon = 1'b0;
        repeat (l) @(negedge clk_in);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_period"},    int'(period),    0);
        chk({tag, "_high_time"}, int'(high_time), 0);
        chk({tag, "_valid"},     int'(valid),     0);
        chk({tag, "_lost"},      int'(lost),      0);
    endtask

    initial begin
        int vs;
        valid_seen = 0;
        reset   = 1'b1;
        enable  = 1'b0;
        clk_mon = 1'b0;
        #1;
        check_zero("reset");
        repeat (3) @(negedge clk_in);
        reset = 1'b0;

        // 25 MHz from a divide-by-4: 2 high / 2 low.
        enable = 1'b1;
        repeat (10) mon(2, 2);
        chk("div4_period", int'(period), 4);
        chk("div4_high",   int'(high_time), 2);
        chk("div4_lost",   int'(lost), 0);

        // 3 high / 7 low.
        repeat (6) mon(3, 7);
        chk("p10_period", int'(period), 10);
        chk("p10_high",   int'(high_time), 3);

        // Loss of clock: stuck low, then recovery.
        vs = valid_seen;
        repeat (4200) @(negedge clk_in);
        chk("loss_lost",     int'(lost), 1);
        chk("loss_period",   int'(period), 10);
        chk("loss_novalid",  valid_seen - vs, 0);
        repeat (3) mon(3, 7);
        chk("recover_lost",   int'(lost), 0);
        chk("recover_period", int'(period), 10);

        // Drop enable 5 cycles into a period, idle a while, then re-enable.
        clk_mon = 1'b1;
        repeat (3) @(negedge clk_in);
        clk_mon = 1'b0;
        repeat (2) @(negedge clk_in);
        enable = 1'b0;
        vs = valid_seen;
        repeat (5) @(negedge clk_in);
        repeat (2) mon(3, 7);
        chk("disabled_novalid", valid_seen - vs, 0);
        enable = 1'b1;
        repeat (4) mon(4, 6);
        chk("reen_period", int'(period), 10);
        chk("reen_high",   int'(high_time), 4);

        // Randomised periods with occasional enable drops.
        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                enable = 1'b0;
                repeat ($urandom_range(1, 6)) @(negedge clk_in);
                enable = 1'b1;
            end
            mon($urandom_range(1, 9), $urandom_range(1, 9));
        end

        // Asynchronous reset between clk_in edges.
        mon(2, 1);
        @(posedge clk_in);
        #3;
        reset = 1'b1;
        #1;
        check_zero("async_rst");
        @(negedge clk_in);
        reset = 1'b0;
        repeat (5) mon(5, 3);
        chk("post_rst_period", int'(period), 8);
        chk("post_rst_high",   int'(high_time), 5);

        // Rise on the very last cycle before timeout: period 4095.
        repeat (3) mon(1, TO - 1);
        chk("edge_period", int'(period), TO);
        chk("edge_high",   int'(high_time), 1);
        chk("edge_lost",   int'(lost), 0);

        repeat (5) @(negedge clk_in);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
